// File: rtl/max_scan_if.sv
// Handshake bundle for max_scan_controller: start/count, operand stream, result stream.
// The max_idx member exists only when MAXSCAN_INDEX_EN is defined.
interface max_scan_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 4
);
  logic                  start;
  logic [CNT_W-1:0]      count;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   max;
`ifdef MAXSCAN_INDEX_EN
  logic [CNT_W-1:0]      max_idx;
`endif
  logic                  busy;

  modport master (
    output start, count, in_valid, in_data, out_ready,
    input  in_ready, out_valid, max, busy
`ifdef MAXSCAN_INDEX_EN
    , input max_idx
`endif
  );

  modport slave (
    input  start, count, in_valid, in_data, out_ready,
    output in_ready, out_valid, max, busy
`ifdef MAXSCAN_INDEX_EN
    , output max_idx
`endif
  );
endinterface

// File: rtl/max_scan_controller.sv
// Streams `count` unsigned operands and reports the first-occurring maximum.
// Define MAXSCAN_INDEX_EN to add the max_idx output and its position counter.
module max_scan_controller #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  max_scan_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_remaining;
  logic [DATA_W-1:0]   r_max;
  logic                r_first;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
`ifdef MAXSCAN_INDEX_EN
  logic [CNT_W-1:0]    r_pos;
  logic [CNT_W-1:0]    r_max_idx;
`endif

  logic                w_xfer;
  logic                w_take;

  assign w_xfer = bus.in_valid && r_in_ready;
  // Strictly-greater compare keeps the earliest operand on ties.
  assign w_take = r_first || (bus.in_data > r_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_max       <= '0;
      r_first     <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef MAXSCAN_INDEX_EN
      r_pos       <= '0;
      r_max_idx   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_remaining <= bus.count;
            r_max       <= '0;
            r_first     <= 1'b1;
            r_busy      <= 1'b1;
`ifdef MAXSCAN_INDEX_EN
            r_pos       <= '0;
            r_max_idx   <= '0;
`endif
            if (bus.count == '0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= S_SCAN;
              r_in_ready  <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (w_xfer) begin
            if (w_take) begin
              r_max     <= bus.in_data;
`ifdef MAXSCAN_INDEX_EN
              r_max_idx <= r_pos;
`endif
            end
            r_first     <= 1'b0;
            r_remaining <= r_remaining - 1'b1;
`ifdef MAXSCAN_INDEX_EN
            r_pos       <= r_pos + 1'b1;
`endif
            if (r_remaining == CNT_W'(1)) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // Result holds until consumed; start is not looked at here.
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.max       = {{DATA_W{1'b0}}, r_max};
`ifdef MAXSCAN_INDEX_EN
  assign bus.max_idx   = r_max_idx;
`endif

endmodule

// File: doc/max_scan_controller.md
MAX_SCAN_CONTROLLER -- requirements
Module: max_scan_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 4, operand width in bits.
REQ-002 SHALL have parameter CNT_W, default 4, width of the operand-count field (up to 2^CNT_W-1 operands).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begin a scan; sampled only in IDLE.
REQ-007 SHALL have port count, input, CNT_W bits: number of operands; latched when start is accepted.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: controller accepts an operand.
REQ-010 SHALL have port in_data, input, DATA_W bits: operand, unsigned.
REQ-011 SHALL have port out_valid, output, 1 bit: result available.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-013 SHALL have port max, output, 2*DATA_W bits: running/final maximum, zero-extended.
REQ-014 SHALL have port max_idx, output, CNT_W bits: 0-based position of the maximum; present only with MAXSCAN_INDEX_EN.
REQ-015 SHALL have port busy, output, 1 bit: high in SCAN or DONE.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-017 IDLE: in_ready=0, out_valid=0; on start=1, latch count into remaining; go to DONE if count==0, else to SCAN.
REQ-018 SCAN: in_ready=1; an operand transfers on in_valid&&in_ready; without in_valid, state and registers hold.
REQ-019 First accepted operand SHALL load the accumulator unconditionally; each later one SHALL replace it only if strictly greater (unsigned).
REQ-020 Ties SHALL keep the earlier operand (first occurrence wins).
REQ-021 remaining SHALL decrement per transfer; the transfer with remaining==1 SHALL move FSM to DONE on the next edge.
REQ-022 DONE: out_valid=1, max and max_idx held stable until out_ready=1; the handshake cycle returns FSM to IDLE.
REQ-023 out_valid SHALL assert exactly one cycle after the last operand transfer (one cycle after start when count==0).
REQ-024 start SHALL be ignored outside IDLE, including the DONE handshake cycle.
REQ-025 count==0 SHALL produce max=0, max_idx=0.
REQ-026 max[2*DATA_W-1:DATA_W] SHALL always be 0.
REQ-027 A new scan SHALL clear the accumulator and index on the start-acceptance edge.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, with in_ready, out_valid, busy, max, max_idx and remaining all 0, regardless of state.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-030 Macro MAXSCAN_INDEX_EN defined: the max_idx port and position counter SHALL exist, with values per REQ-019..REQ-025.
REQ-031 Macro MAXSCAN_INDEX_EN undefined: max_idx and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 count=4, in_data 3,9,2,7 on consecutive cycles -> out_valid one cycle after the 4th transfer, max=8'h09, max_idx=1.
REQ-033 count=3, in_data 5,5,5 -> max=8'h05, max_idx=0 (tie keeps first).
REQ-034 count=0 with start -> out_valid next cycle, max=0, max_idx=0, in_ready never 1.
REQ-035 count=2 with 2-cycle in_valid gap and out_ready low for 3 cycles in DONE, start pulsed in DONE -> max stable, start ignored, IDLE after out_ready.
REQ-036 rst_n=0 mid-SCAN after 2 of 5 operands -> outputs 0 asynchronously; new scan count=1, in_data 4'hF -> max=8'h0F.
